// File: rtl/intel_fpga_pb_debounce_array.sv
// rtl/intel_fpga_pb_debounce_array.sv - multi-channel pushbutton debounce with press/release/long-press events
// One shared sample-tick prescaler; each channel has its own synchroniser, holdoff FSM and hold counter.
module intel_fpga_pb_debounce_array #(
  parameter int NUM_CH         = 4,
  parameter int SAMPLE_DIV     = 50000,
  parameter int HOLDOFF_CNT    = 63,
  parameter int SYNC_STAGES    = 2,
  parameter int ACTIVE_LOW     = 1,
  parameter int LONG_PRESS_CNT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_pb,
  output logic [NUM_CH-1:0] o_pb,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_long_press,
  output logic              o_sample_tick
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = $clog2(HOLDOFF_CNT + 1);
  localparam int LW = (LONG_PRESS_CNT > 0) ? $clog2(LONG_PRESS_CNT + 1) : 1;

  localparam logic [PW-1:0] DIV_LAST  = PW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CNT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_PRESS_CNT);
  localparam logic          REL_LEVEL = (ACTIVE_LOW != 0);

  typedef enum logic {ST_STABLE, ST_HOLDOFF} state_t;

  logic [PW-1:0] div_q, div_d;
  logic          sample_tick_q, sample_tick_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    sample_tick_d = tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  assign o_sample_tick = sample_tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic                   pb_q, pb_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   pb_n;

    assign pb_n = sync_q[SYNC_STAGES-1] ^ REL_LEVEL;

    always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], i_pb[g]};
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      pb_d      = pb_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick) begin
        case (state_q)
          ST_STABLE: begin
            if (pb_n != pb_q) begin
              pb_d      = pb_n;
              hcnt_d    = HOLD_LOAD;
              state_d   = ST_HOLDOFF;
              press_d   = pb_n;
              release_d = ~pb_n;
            end
          end
          ST_HOLDOFF: begin
            // Input is deliberately ignored here; that is what rejects contact bounce.
            hcnt_d = hcnt_q - 1'b1;
            if (hcnt_q == HOLD_LAST) state_d = ST_STABLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q    <= {SYNC_STAGES{REL_LEVEL}};
        state_q   <= ST_STABLE;
        hcnt_q    <= '0;
        pb_q      <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= sync_d;
        state_q   <= state_d;
        hcnt_q    <= hcnt_d;
        pb_q      <= pb_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign o_pb[g]      = pb_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;

    if (LONG_PRESS_CNT > 0) begin : g_long
      logic          accept;
      logic [LW-1:0] lcnt_q, lcnt_d;
      logic          long_q, long_d;

      assign accept = (state_q == ST_STABLE) && (pb_n != pb_q);

      always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (tick) begin
          // An accepted edge restarts the hold count; saturation gives one pulse per hold.
          if (accept) begin
            lcnt_d = '0;
          end else if (pb_q && (lcnt_q < LONG_MAX)) begin
            lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_d == LONG_MAX);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lcnt_q <= '0;
          long_q <= 1'b0;
        end else begin
          lcnt_q <= lcnt_d;
          long_q <= long_d;
        end
      end

      assign o_long_press[g] = long_q;
    end else begin : g_no_long
      assign o_long_press[g] = 1'b0;
    end
  end

endmodule
